game_pacman: RTL and testbench

- Pac-Man motion controller; drives the player sprite position and heading.
- Inputs: joystick requests, plus the 4-neighbour tile info that maze returns for Pac-Man's current tile.
- Outputs pixel position, direction and tile coordinates. These feed maze (pellet eating, tile lookup) and every game_ghost instance (chase targeting).
- Sits directly upstream of game_ghost. Replaces the hand-driven pacman_x/pacman_y/pacman_dir stimulus.

---
 rtl/game_pkg.sv | 45 ++++
 rtl/game_tick_div.sv | 31 +++
 rtl/game_pacman.sv | 152 +++++++++++++++
 tb/tb_game_pacman.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the game sprite controllers: direction and tile codes,
// maze geometry and small helpers used by Pac-Man and the ghosts.
package game_pkg;

  localparam int unsigned POS_W           = 10;
  localparam int unsigned TILE_W          = 7;
  localparam int unsigned TILE_CENTER_OFF = 3;
  localparam int unsigned TILE_Y_OFFSET   = 3;
  localparam int unsigned MAZE_MAX_X      = 223;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_UP    = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    TILE_OPEN   = 2'b00,
    TILE_WALL   = 2'b01,
    TILE_DOOR   = 2'b10,
    TILE_PELLET = 2'b11
  } tile_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_MOVE  = 2'b01,
    ST_DYING = 2'b10
  } pac_state_t;

  typedef struct packed {
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
  } pos_t;

  // Reversing a heading flips the axis-sign bit of the code.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

  function automatic logic blocked(input logic [1:0] t);
    return (t == TILE_WALL) || (t == TILE_DOOR);
  endfunction

endpackage

// File: rtl/game_tick_div.sv
// Move-step prescaler: counts 0..DIV-1 while enabled, tick_c on the last count.
module game_tick_div
  import game_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  assign tick_c = en && !clr && (count == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick_c ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/game_pacman.sv
// Pac-Man motion controller: joystick turn buffer, tile-centred turning,
// wall stops, tunnel wrap and the death/respawn sequence.
module game_pacman
  import game_pkg::*;
#(
  parameter int unsigned MOVE_DIV    = 4,
  parameter int unsigned START_X     = 119,
  parameter int unsigned START_Y     = 227,
  parameter int unsigned DEATH_TICKS = 64,
  parameter int unsigned MAX_X       = MAZE_MAX_X
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        dir_req,
  input  logic              dir_req_valid,
  input  logic [3:0][1:0]   tile_info,
  input  logic              caught,
  output logic [POS_W-1:0]  pacman_x,
  output logic [POS_W-1:0]  pacman_y,
  output logic [1:0]        pacman_dir,
  output logic [TILE_W-1:0] pacman_xtile,
  output logic [TILE_W-1:0] pacman_ytile,
  output logic              moving,
  output logic              dying
);

  localparam int unsigned DW = (DEATH_TICKS > 1) ? $clog2(DEATH_TICKS) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DEATH_TICKS - 1);

  pac_state_t    state_q, state_d;
  pos_t          pos_q, pos_d, pos_step;
  dir_t          dir_q, dir_d, buf_q, buf_d, eff_dir;
  logic          buf_v_q, buf_v_d;
  logic          moving_q, moving_d, dying_q;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          run, tick, centred, reverse, turn_ok, stop;

  assign run = (state_q == ST_MOVE) || (state_q == ST_DYING);

  game_tick_div #(.DIV(MOVE_DIV)) u_tick_div (
    .clk    (clk),
    .rst    (rst),
    .en     (run),
    .clr    (!run),
    .tick_c (tick)
  );

  function automatic pos_t step_pos(input pos_t p, input dir_t d);
    pos_t n;
    n = p;
    case (d)
      DIR_RIGHT: n.x = (p.x == POS_W'(MAX_X)) ? '0 : p.x + POS_W'(1);
      DIR_UP:    n.y = p.y - POS_W'(1);
      DIR_LEFT:  n.x = (p.x == '0) ? POS_W'(MAX_X) : p.x - POS_W'(1);
      default:   n.y = p.y + POS_W'(1);
    endcase
    return n;
  endfunction

  // Heading for this step: reversals apply anywhere, other turns only at a centre.
  always_comb begin
    centred  = (pos_q.x[2:0] == 3'(TILE_CENTER_OFF)) && (pos_q.y[2:0] == 3'(TILE_CENTER_OFF));
    reverse  = buf_v_q && (buf_q == opposite(dir_q));
    turn_ok  = !reverse && centred && buf_v_q && !blocked(tile_info[buf_q]);
    eff_dir  = (reverse || turn_ok) ? buf_q : dir_q;
    stop     = centred && blocked(tile_info[eff_dir]);
    pos_step = step_pos(pos_q, eff_dir);
  end

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    buf_d    = buf_q;
    buf_v_d  = buf_v_q;
    moving_d = moving_q;
    dcnt_d   = dcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_MOVE;
      end
      ST_MOVE: begin
        if (caught) begin
          state_d  = ST_DYING;
          moving_d = 1'b0;
          buf_v_d  = 1'b0;
          dcnt_d   = '0;
        end else if (tick) begin
          dir_d = eff_dir;
          if (reverse || turn_ok) buf_v_d = 1'b0;
          if (stop) begin
            moving_d = 1'b0;
          end else begin
            pos_d    = pos_step;
            moving_d = 1'b1;
          end
        end
      end
      ST_DYING: begin
        if (tick) begin
          if (dcnt_q == DLAST) begin
            state_d = ST_IDLE;
            pos_d.x = POS_W'(START_X);
            pos_d.y = POS_W'(START_Y);
            dir_d   = DIR_LEFT;
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A fresh request wins over clearing an entry that was just applied.
    if (dir_req_valid && (state_q != ST_DYING) && !((state_q == ST_MOVE) && caught)) begin
      buf_d   = dir_t'(dir_req);
      buf_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      pos_q.x  <= POS_W'(START_X);
      pos_q.y  <= POS_W'(START_Y);
      dir_q    <= DIR_LEFT;
      buf_q    <= DIR_RIGHT;
      buf_v_q  <= 1'b0;
      moving_q <= 1'b0;
      dying_q  <= 1'b0;
      dcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      buf_q    <= buf_d;
      buf_v_q  <= buf_v_d;
      moving_q <= moving_d;
      dying_q  <= (state_d == ST_DYING);
      dcnt_q   <= dcnt_d;
    end
  end

  assign pacman_x     = pos_q.x;
  assign pacman_y     = pos_q.y;
  assign pacman_dir   = dir_q;
  assign moving       = moving_q;
  assign dying        = dying_q;
  assign pacman_xtile = TILE_W'(pos_q.x >> 3);
  assign pacman_ytile = TILE_W'((pos_q.y >> 3) - POS_W'(TILE_Y_OFFSET));

endmodule

// File: tb/tb_game_pacman.sv
// Bench for game_pacman: a cycle reference model pushes expected outputs each
// clock; they are popped and compared on the following falling edge.
module tb_game_pacman;

  localparam int DIV = 2;
  localparam int DT  = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [1:0]     dir_req;
  logic           dir_req_valid;
  logic [3:0][1:0] ti;
  logic           caught;
  logic [9:0]     pacman_x, pacman_y;
  logic [1:0]     pacman_dir;
  logic [6:0]     pacman_xtile, pacman_ytile;
  logic           moving, dying;

  game_pacman #(
    .MOVE_DIV(DIV), .START_X(119), .START_Y(227), .DEATH_TICKS(DT), .MAX_X(223)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .dir_req(dir_req),
    .dir_req_valid(dir_req_valid), .tile_info(ti), .caught(caught),
    .pacman_x(pacman_x), .pacman_y(pacman_y), .pacman_dir(pacman_dir),
    .pacman_xtile(pacman_xtile), .pacman_ytile(pacman_ytile),
    .moving(moving), .dying(dying)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int x; int y; int dir; int mov; int dy;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state (0=IDLE 1=MOVE 2=DYING)
  int m_st, m_x, m_y, m_dir, m_buf, m_bv, m_mov, m_cnt, m_dc;

  function automatic bit blk(input logic [1:0] t);
    return (t == 2'b01) || (t == 2'b10);
  endfunction

  always @(posedge clk) begin : model
    bit run, tk, cen;
    int nd, nst, ncnt;
    exp_t e;
    if (!rst) begin
      m_st = 0; m_x = 119; m_y = 227; m_dir = 2; m_buf = 0; m_bv = 0;
      m_mov = 0; m_cnt = 0; m_dc = 0;
    end else begin
      run  = (m_st != 0);
      tk   = run && (m_cnt == DIV - 1);
      ncnt = (run && !tk) ? m_cnt + 1 : 0;
      nst  = m_st;
      if (m_st == 0) begin
        if (start) nst = 1;
        if (dir_req_valid) begin m_buf = dir_req; m_bv = 1; end
      end else if (m_st == 1) begin
        if (caught) begin
          nst = 2; m_mov = 0; m_bv = 0; m_dc = 0;
        end else begin
          if (tk) begin
            cen = (m_x % 8 == 3) && (m_y % 8 == 3);
            nd = m_dir;
            if (m_bv && m_buf == (m_dir ^ 2)) begin nd = m_buf; m_bv = 0; end
            else if (cen && m_bv && !blk(ti[m_buf])) begin nd = m_buf; m_bv = 0; end
            m_dir = nd;
            if (cen && blk(ti[nd])) m_mov = 0;
            else begin
              m_mov = 1;
              case (nd)
                0: m_x = (m_x == 223) ? 0 : m_x + 1;
                1: m_y = m_y - 1;
                2: m_x = (m_x == 0) ? 223 : m_x - 1;
                default: m_y = m_y + 1;
              endcase
            end
          end
          if (dir_req_valid) begin m_buf = dir_req; m_bv = 1; end
        end
      end else begin
        if (tk) begin
          if (m_dc == DT - 1) begin nst = 0; m_x = 119; m_y = 227; m_dir = 2; end
          else m_dc = m_dc + 1;
        end
      end
      m_st = nst;
      m_cnt = ncnt;
    end
    e.x = m_x; e.y = m_y; e.dir = m_dir; e.mov = m_mov; e.dy = (m_st == 2) ? 1 : 0;
    exp_q.push_back(e);
  end

  always @(negedge clk) begin : scoreboard
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("x", pacman_x, e.x);
      check("y", pacman_y, e.y);
      check("dir", pacman_dir, e.dir);
      check("moving", moving, e.mov);
      check("dying", dying, e.dy);
      check("xtile", pacman_xtile, e.x >> 3);
      check("ytile", pacman_ytile, ((e.y >> 3) - 3) & 127);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic req(input logic [1:0] d);
    dir_req = d; dir_req_valid = 1'b1;
    cyc(1);
    dir_req_valid = 1'b0;
  endtask

  task automatic wait_x(input string tag, input int v, input int budget);
    int n;
    n = 0;
    while (pacman_x !== 10'(v) && n < budget) begin cyc(1); n++; end
    check(tag, pacman_x, v);
  endtask

  task automatic wait_y(input string tag, input int v, input int budget);
    int n;
    n = 0;
    while (pacman_y !== 10'(v) && n < budget) begin cyc(1); n++; end
    check(tag, pacman_y, v);
  endtask

  initial begin
    int n;
    logic [9:0] x0;
    rst = 1'b0; start = 1'b0; dir_req = 2'b00; dir_req_valid = 1'b0; caught = 1'b0;
    ti = '0;
    cyc(3);
    rst = 1'b1;
    cyc(20);
    check("rst_x", pacman_x, 119);
    check("rst_y", pacman_y, 227);
    check("rst_dir", pacman_dir, 2);
    check("rst_moving", moving, 0);
    check("rst_dying", dying, 0);
    check("rst_ytile", pacman_ytile, 25);

    // Wall stop on the left at the next centre
    ti[2] = 2'b01;
    start = 1'b1;
    wait_x("first_step", 118, 10);
    check("first_moving", moving, 1);
    wait_x("wall_reach", 115, 20);
    cyc(10);
    check("wall_hold_x", pacman_x, 115);
    check("wall_hold_moving", moving, 0);

    // Restart from the wall by turning up
    req(2'b01);
    wait_y("up_step", 226, 10);
    check("up_dir", pacman_dir, 1);
    check("up_x", pacman_x, 115);

    // Off-centre reversal
    wait_y("up_run", 224, 10);
    req(2'b11);
    wait_y("rev_step", 225, 10);
    check("rev_dir", pacman_dir, 3);

    // Buffered turn waits for the centre at y=227
    ti = '0;
    req(2'b10);
    wait_y("buf_pass", 227, 10);
    check("buf_still_down", pacman_dir, 3);
    wait_x("buf_turn", 114, 10);
    check("buf_turn_y", pacman_y, 227);
    check("buf_turn_dir", pacman_dir, 2);

    // Tunnel both ways
    wait_x("tunnel_zero", 0, 400);
    wait_x("tunnel_wrap_l", 223, 10);
    req(2'b00);
    wait_x("tunnel_wrap_r", 0, 10);
    check("tunnel_dir", pacman_dir, 0);
    check("tunnel_xtile", pacman_xtile, 0);

    // Caught on a tick cycle: step dropped
    wait_x("pre_death", 3, 20);
    n = 0;
    while (!(m_st == 1 && m_cnt == DIV - 1) && n < 10) begin cyc(1); n++; end
    check("tick_found", n < 10, 1);
    caught = 1'b1;
    x0 = pacman_x;
    cyc(1);
    caught = 1'b0;
    check("death_x", pacman_x, x0);
    check("death_dying", dying, 1);
    check("death_moving", moving, 0);
    cyc(3);
    caught = 1'b1; start = 1'b1;
    cyc(1);
    caught = 1'b0; start = 1'b0;
    check("death_ignore", dying, 1);
    n = 0;
    while (dying !== 1'b0 && n < 100) begin cyc(1); n++; end
    check("respawn_dying", dying, 0);
    check("respawn_x", pacman_x, 119);
    check("respawn_y", pacman_y, 227);
    check("respawn_dir", pacman_dir, 2);
    cyc(5);
    check("idle_hold_x", pacman_x, 119);

    // Asynchronous reset in the middle of a run
    start = 1'b1;
    wait_x("run_again", 117, 20);
    rst = 1'b0;
    #1;
    check("async_x", pacman_x, 119);
    check("async_moving", moving, 0);
    check("async_dir", pacman_dir, 2);
    cyc(3);
    rst = 1'b1; start = 1'b0;
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
